// File: rtl/uart_alu_intf.sv
// uart_alu_intf
//   Glue between a UART receiver, a combinational ALU and a UART transmitter.
//   Three received bytes (operand A, operand B, opcode) are collected into
//   registers that drive the ALU. The ALU result is captured one cycle later
//   and handed to the transmitter with a start/done handshake. A partial frame
//   is abandoned when the gap between its bytes reaches TIMEOUT cycles.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous reset, active low
//   i_rx_done_tick  receiver strobe: i_rx_data is valid
//   i_rx_data       received byte
//   i_alu_result    combinational ALU output
//   i_tx_done_tick  transmitter strobe: frame sent
//   o_data_a        operand A register
//   o_data_b        operand B register
//   o_op            opcode register (low NB_OP bits of the third byte)
//   o_tx_start      one-cycle start strobe to the transmitter
//   o_tx_data       result register to the transmitter
//   o_timeout       one-cycle pulse when a partial frame is abandoned
//   o_overrun       one-cycle pulse when a received byte is dropped
module uart_alu_intf #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned TIMEOUT = 16'd50000,
    parameter int unsigned NB_TOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_timeout,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    localparam bit               TOUT_EN   = (TIMEOUT != 0);
    localparam logic [NB_TOUT-1:0] TOUT_LAST = NB_TOUT'(TIMEOUT - 1);

    state_t             state, state_next;
    logic [NB_DATA-1:0] a_q, b_q, res_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_TOUT-1:0] cnt_q;
    logic               tx_start_q, timeout_q, overrun_q;

    logic load_a, load_b, load_op, load_res;
    logic cnt_run, cnt_clr, clr_all;
    logic start_nxt, timeout_nxt, overrun_nxt;
    logic tout_hit;

    // A byte arriving on the last allowed cycle wins over the timeout
    // because the rx checks below come first in each waiting state.
    assign tout_hit = TOUT_EN && (cnt_q == TOUT_LAST);

    always_comb begin
        state_next  = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        load_res    = 1'b0;
        cnt_run     = 1'b0;
        cnt_clr     = 1'b0;
        clr_all     = 1'b0;
        start_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            GET_A: begin
                if (i_rx_done_tick) begin
                    load_a     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done_tick) begin
                    load_b     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = GET_OP;
                end else if (tout_hit) begin
                    timeout_nxt = 1'b1;
                    cnt_clr     = 1'b1;
                    state_next  = GET_A;
                end else begin
                    cnt_run = TOUT_EN;
                end
            end
            GET_OP: begin
                if (i_rx_done_tick) begin
                    load_op    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = EXEC;
                end else if (tout_hit) begin
                    timeout_nxt = 1'b1;
                    cnt_clr     = 1'b1;
                    state_next  = GET_A;
                end else begin
                    cnt_run = TOUT_EN;
                end
            end
            EXEC: begin
                load_res    = 1'b1;
                start_nxt   = 1'b1;
                overrun_nxt = i_rx_done_tick;
                state_next  = SEND;
            end
            SEND: begin
                overrun_nxt = i_rx_done_tick;
                state_next  = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_nxt = i_rx_done_tick;
                if (i_tx_done_tick) state_next = GET_A;
            end
            default: begin
                clr_all    = 1'b1;
                state_next = GET_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= GET_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_next;
            tx_start_q <= start_nxt;
            timeout_q  <= timeout_nxt;
            overrun_q  <= overrun_nxt;
            if (clr_all) begin
                a_q   <= '0;
                b_q   <= '0;
                op_q  <= '0;
                res_q <= '0;
                cnt_q <= '0;
            end else begin
                if (load_a)   a_q   <= i_rx_data;
                if (load_b)   b_q   <= i_rx_data;
                if (load_op)  op_q  <= i_rx_data[NB_OP-1:0];
                if (load_res) res_q <= i_alu_result;
                if (cnt_clr)      cnt_q <= '0;
                else if (cnt_run) cnt_q <= cnt_q + NB_TOUT'(1);
            end
        end
    end

    assign o_data_a   = a_q;
    assign o_data_b   = b_q;
    assign o_op       = op_q;
    assign o_tx_data  = res_q;
    assign o_tx_start = tx_start_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// tb_uart_alu_intf
//   Self-checking bench for uart_alu_intf (TIMEOUT=20). Frames come from a
//   vector table; expected result bytes go into a scoreboard queue and are
//   compared whenever the DUT raises o_tx_start. Timeout, overrun and reset
//   corner cases are hand-written sequences.
module tb_uart_alu_intf;

    localparam int unsigned TOUT = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic [7:0] rx_data = '0;
    logic [7:0] alu_result;
    logic       tx_done = 1'b0;
    logic [7:0] data_a, data_b, tx_data;
    logic [5:0] op;
    logic       tx_start, timeout, overrun;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_tout = 0;
    int n_ovr = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    uart_alu_intf #(
        .NB_DATA(8),
        .NB_OP  (6),
        .TIMEOUT(TOUT),
        .NB_TOUT(16)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_rx_done_tick(rx_tick),
        .i_rx_data     (rx_data),
        .i_alu_result  (alu_result),
        .i_tx_done_tick(tx_done),
        .o_data_a      (data_a),
        .o_data_b      (data_b),
        .o_op          (op),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .o_timeout     (timeout),
        .o_overrun     (overrun)
    );

    // Reference ALU attached to the DUT's operand outputs
    always_comb begin
        case (op)
            6'h20:   alu_result = data_a + data_b;
            6'h22:   alu_result = data_a - data_b;
            6'h24:   alu_result = data_a & data_b;
            6'h25:   alu_result = data_a | data_b;
            6'h26:   alu_result = data_a ^ data_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer and pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (timeout) n_tout++;
        if (overrun) n_ovr++;
        if (tx_start) begin
            n_start++;
            if (sb_q.size() == 0) begin
                check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check("tx_data_at_start", {24'd0, tx_data}, {24'd0, e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    task automatic tx_ack();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Sends a frame and checks the start pulse lands exactly 2 cycles after
    // the opcode byte cycle and lasts one cycle. Leaves the DUT in WAIT_TX.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opc, input logic [7:0] exp);
        sb_q.push_back(exp);
        send_byte(a);
        send_byte(b);
        send_byte(opc);
        check("op_reg", {26'd0, op}, {26'd0, opc[5:0]});
        check("no_start_in_exec", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("start_latency", {31'd0, tx_start}, 32'd1);
        @(negedge clk);
        check("start_single", {31'd0, tx_start}, 32'd0);
        check("tx_data_hold", {24'd0, tx_data}, {24'd0, exp});
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opc;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_k;
        int t0;
        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
        vecs[1] = '{8'h05, 8'h07, 8'h22, 8'hFE};
        vecs[2] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
        vecs[3] = '{8'hC3, 8'h5A, 8'hE6, 8'h99};   // opcode high bits ignored -> XOR
        vecs[4] = '{8'hFF, 8'h01, 8'h20, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a",  {24'd0, data_a}, 32'd0);
        check("rst_b",  {24'd0, data_b}, 32'd0);
        check("rst_op", {26'd0, op}, 32'd0);
        check("rst_pulses", {29'd0, tx_start, timeout, overrun}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // Table-driven frames, back to back
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].exp);
            tx_ack();
        end

        // Timeout after a lone byte
        t0 = n_tout;
        send_byte(8'h11);
        first_k = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (timeout && first_k == 0) first_k = k;
        end
        check("timeout_cycle", first_k, TOUT);
        check("timeout_count", n_tout - t0, 1);
        check("timeout_keeps_a", {24'd0, data_a}, 32'h11);
        run_frame(8'h01, 8'h02, 8'h20, 8'h03);
        tx_ack();

        // Byte arriving on the last allowed cycle in GET_B is accepted
        t0 = n_tout;
        sb_q.push_back(8'h77);
        send_byte(8'h33);
        repeat (TOUT - 2) @(negedge clk);
        send_byte(8'h44);
        check("boundary_b_taken", {24'd0, data_b}, 32'h44);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        check("boundary_no_timeout", n_tout - t0, 0);
        tx_ack();

        // Overrun during WAIT_TX
        t0 = n_ovr;
        run_frame(8'h10, 8'h20, 8'h20, 8'h30);
        send_byte(8'hAA);
        @(negedge clk);
        check("overrun_count", n_ovr - t0, 1);
        check("overrun_tx_data", {24'd0, tx_data}, 32'h30);
        check("overrun_a", {24'd0, data_a}, 32'h10);
        tx_ack();
        run_frame(8'h09, 8'h04, 8'h22, 8'h05);
        tx_ack();

        // Asynchronous reset during WAIT_TX
        run_frame(8'h21, 8'h12, 8'h26, 8'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {data_a, data_b, op, tx_start, timeout, overrun, 1'b0},
              32'd0);
        check("async_rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = n_start;
        tx_ack();
        send_byte(8'h06);
        send_byte(8'h02);
        repeat (5) @(negedge clk);
        check("no_start_partial", n_start - t0, 0);
        sb_q.push_back(8'h04);
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        check("start_after_full", n_start - t0, 1);
        tx_ack();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_alu_intf.md
Name: uart_alu_intf

Overview:
- Sits directly downstream of the UART receiver and upstream of the UART transmitter and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents the three bytes to the ALU, captures the ALU result, then hands that result to the transmitter with a start/done handshake.
- Includes an inter-byte timeout that abandons a partial frame.

Parameters:
- NB_DATA, 8, width of receiver bytes, operands and ALU result.
- NB_OP, 6, opcode width; the low NB_OP bits of the third byte are used.
- TIMEOUT, 16'd50000, clock cycles allowed between bytes of one frame; 0 disables the timeout.
- NB_TOUT, 16, width of the timeout counter.

Ports:
- i_clk  in  1  system clock; all registers update on the rising edge.
- i_reset_n  in  1  asynchronous reset, active-low.
- i_rx_done_tick  in  1  one-cycle strobe from the receiver: a byte is valid.
- i_rx_data  in  NB_DATA  received byte; sampled only when i_rx_done_tick=1.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done_tick  in  1  one-cycle strobe from the transmitter: frame sent.
- o_data_a  out  NB_DATA  registered operand A to the ALU.
- o_data_b  out  NB_DATA  registered operand B to the ALU.
- o_op  out  NB_OP  registered opcode to the ALU.
- o_tx_start  out  1  one-cycle start strobe to the transmitter.
- o_tx_data  out  NB_DATA  registered result byte to the transmitter.
- o_timeout  out  1  one-cycle pulse when a partial frame is abandoned.
- o_overrun  out  1  one-cycle pulse when a received byte is dropped.

Behaviour:
- Reset (i_reset_n=0, asynchronous): state=GET_A; the a, b, op and result registers and the timeout counter are cleared to 0. All outputs are 0.
- Structure: registered FSM, a combinational next-state block, and registered pulse outputs (o_tx_start, o_timeout, o_overrun).
- GET_A: on i_rx_done_tick, a<=i_rx_data, clear the counter, go to GET_B. No timeout runs in this state.
- GET_B: on i_rx_done_tick, b<=i_rx_data, clear the counter, go to GET_OP.
- GET_OP: on i_rx_done_tick, op<=i_rx_data[NB_OP-1:0], go to EXEC.
- Timeout in GET_B and GET_OP:
  - The counter increments each cycle.
  - When counter==TIMEOUT-1 and no done tick is present, go to GET_A, pulse o_timeout for 1 cycle, and clear the counter.
  - The a, b and op registers keep their old values.
  - If a done tick arrives in the same cycle, the byte wins and no timeout occurs.
  - TIMEOUT=0: the counter is held at 0 and never fires.
- EXEC: lasts exactly 1 cycle. o_data_a/o_data_b/o_op are stable and were updated on the previous edge. result<=i_alu_result, then go to SEND.
- SEND: lasts 1 cycle. o_tx_start=1 and o_tx_data=result (result is already valid). Go to WAIT_TX.
- WAIT_TX: hold o_tx_data. On i_tx_done_tick, go to GET_A.
- i_tx_done_tick outside WAIT_TX is ignored.
- Latency: the o_tx_start pulse occurs 2 cycles after the cycle in which the opcode done tick is sampled.
- Overrun: an i_rx_done_tick during EXEC, SEND or WAIT_TX is dropped and o_overrun pulses for 1 cycle. All registers and state are unchanged.
- o_data_a, o_data_b and o_op always reflect the registers, including during partial frames. The ALU output is only meaningful at EXEC.
- Illegal or unused state encodings go to GET_A with registers cleared, mirroring reset.
- Reset mid-frame or mid-transmit: immediate return to GET_A. o_tx_start is never asserted again for the aborted frame.

Test Plan:
- Reset release, then bytes 0x05, 0x03, 0x20 (ALU model: ADD = a+b) -> o_op=0x20, a single o_tx_start pulse with o_tx_data=0x08. After a tx done tick, the FSM is back in GET_A.
- Bytes 0x05, 0x07, 0x22 (SUB) -> o_tx_data=0xFE (8-bit wrap). Back-to-back second frame 0xF0, 0x0F, 0x25 (OR) -> 0xFF.
- TIMEOUT=20; send 0x11, then wait 20 cycles -> o_timeout pulses exactly once on the 20th cycle after the byte. The next bytes 0x01, 0x02, 0x20 give result 0x03.
- Done tick arriving exactly on cycle TIMEOUT-1 in GET_B -> byte accepted, no o_timeout.
- rx done tick (0xAA) during WAIT_TX -> o_overrun pulses 1 cycle, o_tx_data unchanged, the next frame is unaffected.
- Assert i_reset_n=0 during WAIT_TX -> all outputs 0 asynchronously. After release, no o_tx_start until a full 3-byte frame is received.
